// File: rtl/rf_pkg.sv
// Shared register-file constants and types for regfile_mp and its write arbiter.
package rf_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int AW_DEF   = $clog2(NREG_DEF);

  typedef logic [AW_DEF-1:0] rf_addr_t;

  localparam rf_addr_t ZERO_ADDR = '0;
endpackage

// File: rtl/rf_wr_arbiter.sv
// Combinational write arbiter: per-register write hit plus the winning data,
// highest-index port wins. Shared by the storage write path and the read bypass.
module rf_wr_arbiter
  import rf_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREG     = NREG_DEF,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   wa,
  input  logic [NWR*XLEN-1:0] wd,
  output logic [NREG-1:0]     hit,
  output logic [XLEN-1:0]     sel_wd [NREG]
);

  // Ascending scan so later (higher-index) ports overwrite earlier ones.
  always_comb begin
    hit = '0;
    for (int k = 0; k < NREG; k++) begin
      sel_wd[k] = '0;
    end
    for (int i = 0; i < NWR; i++) begin
      if (we[i] && !((ZERO_REG != 0) && (wa[i*AW +: AW] == AW'(ZERO_ADDR)))) begin
        hit[wa[i*AW +: AW]]    = 1'b1;
        sel_wd[wa[i*AW +: AW]] = wd[i*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with optional zero register, write-to-read bypass,
// synchronous clear and a per-register busy scoreboard.
module regfile_mp
  import rf_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREG     = NREG_DEF,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic                CLK,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   wa,
  input  logic [NWR*XLEN-1:0] wd,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic [NREG-1:0]     busy_vec
);

  logic [XLEN-1:0] mem_reg [NREG];
  logic [NREG-1:0] busy_reg;
  logic [NREG-1:0] busy_next;
  logic [NREG-1:0] wr_hit;
  logic [XLEN-1:0] wr_data [NREG];
  logic            rsv_legal;

  rf_wr_arbiter #(
    .XLEN     (XLEN),
    .NREG     (NREG),
    .NWR      (NWR),
    .ZERO_REG (ZERO_REG)
  ) u_arb (
    .we     (we),
    .wa     (wa),
    .wd     (wd),
    .hit    (wr_hit),
    .sel_wd (wr_data)
  );

  assign rsv_legal = rsv_en && !((ZERO_REG != 0) && (rsv_addr == AW'(ZERO_ADDR)));

  // A reserve is applied after the write clear: a new producer supersedes the old one.
  always_comb begin
    busy_next = busy_reg & ~wr_hit;
    if (rsv_legal) begin
      busy_next[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!rst) begin
      busy_reg <= '0;
      for (int k = 0; k < NREG; k++) begin
        mem_reg[k] <= '0;
      end
    end else begin
      busy_reg <= busy_next;
      for (int k = 0; k < NREG; k++) begin
        if (wr_hit[k]) begin
          mem_reg[k] <= wr_data[k];
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0] addr;
      logic          is_zero;
      logic          fwd;

      assign addr    = ra[gi*AW +: AW];
      assign is_zero = (ZERO_REG != 0) && (addr == AW'(ZERO_ADDR));
      assign fwd     = (BYPASS != 0) && wr_hit[addr];

      assign rd[gi*XLEN +: XLEN] = (!rst || is_zero) ? '0 :
                                   fwd ? wr_data[addr] : mem_reg[addr];
      // Forwarded data is already valid, so the pending flag is masked.
      assign rd_busy[gi] = rst && !is_zero && !fwd && busy_reg[addr];
    end
  endgenerate

  assign busy_vec = rst ? busy_reg : '0;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed scenarios plus randomized runs against a reference model,
// on a default instance (bypass on) and a 64-bit/16-entry/3-read/1-write instance (bypass off).
module tb_regfile_mp;
  logic CLK = 1'b0;
  logic rst;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Instance A: defaults (XLEN=32, NREG=32, NRD=2, NWR=2, ZERO_REG=1, BYPASS=1)
  logic [9:0]  ra_a;
  logic [63:0] rd_a;
  logic [1:0]  rd_busy_a;
  logic [1:0]  we_a;
  logic [9:0]  wa_a;
  logic [63:0] wd_a;
  logic        rsv_en_a;
  logic [4:0]  rsv_addr_a;
  logic [31:0] busy_vec_a;

  // Instance B: XLEN=64, NREG=16, NRD=3, NWR=1, ZERO_REG=1, BYPASS=0
  logic [11:0]  ra_b;
  logic [191:0] rd_b;
  logic [2:0]   rd_busy_b;
  logic [0:0]   we_b;
  logic [3:0]   wa_b;
  logic [63:0]  wd_b;
  logic         rsv_en_b;
  logic [3:0]   rsv_addr_b;
  logic [15:0]  busy_vec_b;

  regfile_mp u_a (
    .CLK(CLK), .rst(rst), .ra(ra_a), .rd(rd_a), .rd_busy(rd_busy_a),
    .we(we_a), .wa(wa_a), .wd(wd_a), .rsv_en(rsv_en_a), .rsv_addr(rsv_addr_a),
    .busy_vec(busy_vec_a)
  );

  regfile_mp #(.XLEN(64), .NREG(16), .NRD(3), .NWR(1), .ZERO_REG(1), .BYPASS(0)) u_b (
    .CLK(CLK), .rst(rst), .ra(ra_b), .rd(rd_b), .rd_busy(rd_busy_b),
    .we(we_b), .wa(wa_b), .wd(wd_b), .rsv_en(rsv_en_b), .rsv_addr(rsv_addr_b),
    .busy_vec(busy_vec_b)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    ra_a = '0; we_a = '0; wa_a = '0; wd_a = '0; rsv_en_a = 1'b0; rsv_addr_a = '0;
    ra_b = '0; we_b = '0; wa_b = '0; wd_b = '0; rsv_en_b = 1'b0; rsv_addr_b = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0; idle(); step();
    ra_a = {5'd1, 5'd0}; #1;
    checks++;
    if (rd_a !== 64'h0 || busy_vec_a !== 32'h0 || busy_vec_b !== 16'h0) begin
      errors++; $display("FAIL reset_state rd_a=%h busy_a=%h busy_b=%h want 0", rd_a, busy_vec_a, busy_vec_b);
    end
    rst = 1'b1;
    we_a = 2'b01; wa_a = {5'd0, 5'd5}; wd_a = {32'h0, 32'hDEADBEEF};
    rsv_en_a = 1'b1; rsv_addr_a = 5'd4;
    step(); idle();
    ra_a = {5'd0, 5'd5}; #1;
    checks++;
    if (rd_a[31:0] !== 32'hDEADBEEF || busy_vec_a !== 32'h10) begin
      errors++; $display("FAIL reset_prewrite rd=%h busy=%h want deadbeef/00000010", rd_a[31:0], busy_vec_a);
    end
    rst = 1'b0; #1;
    checks++;
    if (rd_a !== 64'h0 || busy_vec_a !== 32'h0 || rd_busy_a !== 2'b00) begin
      errors++; $display("FAIL reset_gate rd=%h busy=%h rd_busy=%b want 0", rd_a, busy_vec_a, rd_busy_a);
    end
    step(); rst = 1'b1; #1;
    checks++;
    if (rd_a[31:0] !== 32'h0 || busy_vec_a !== 32'h0) begin
      errors++; $display("FAIL reset_clear rd=%h busy=%h want 0", rd_a[31:0], busy_vec_a);
    end
    $display("test_reset done");
  endtask

  task automatic test_zero_reg();
    idle();
    we_a = 2'b01; wa_a = '0; wd_a = {32'h0, 32'hFFFFFFFF};
    rsv_en_a = 1'b1; rsv_addr_a = 5'd0; #1;
    checks++;
    if (rd_a[31:0] !== 32'h0 || rd_busy_a[0] !== 1'b0) begin
      errors++; $display("FAIL zero_same_cycle rd=%h busy=%b want 0/0", rd_a[31:0], rd_busy_a[0]);
    end
    step(); idle(); #1;
    checks++;
    if (rd_a[31:0] !== 32'h0 || busy_vec_a[0] !== 1'b0) begin
      errors++; $display("FAIL zero_after rd=%h busy0=%b want 0/0", rd_a[31:0], busy_vec_a[0]);
    end
    $display("test_zero_reg done");
  endtask

  task automatic test_collision();
    idle();
    we_a = 2'b11; wa_a = {5'd7, 5'd7}; wd_a = {32'h22222222, 32'h11111111};
    ra_a = {5'd0, 5'd7}; #1;
    checks++;
    if (rd_a[31:0] !== 32'h22222222) begin
      errors++; $display("FAIL collision_bypass rd=%h want 22222222", rd_a[31:0]);
    end
    step(); idle(); ra_a = {5'd7, 5'd0}; #1;
    checks++;
    if (rd_a[63:32] !== 32'h22222222) begin
      errors++; $display("FAIL collision_stored rd=%h want 22222222", rd_a[63:32]);
    end
    $display("test_collision done");
  endtask

  task automatic test_bypass();
    idle();
    we_a = 2'b01; wa_a = {5'd0, 5'd3}; wd_a = {32'h0, 32'hA};
    we_b = 1'b1;  wa_b = 4'd3;         wd_b = 64'hA;
    step();
    wd_a = {32'h0, 32'hB}; wd_b = 64'hB;
    ra_a = {5'd0, 5'd3}; ra_b = {4'd0, 4'd0, 4'd3}; #1;
    checks++;
    if (rd_a[31:0] !== 32'hB) begin
      errors++; $display("FAIL bypass_on rd=%h want 0000000b", rd_a[31:0]);
    end
    checks++;
    if (rd_b[63:0] !== 64'hA) begin
      errors++; $display("FAIL bypass_off_pre rd=%h want a", rd_b[63:0]);
    end
    step(); we_a = '0; we_b = '0; #1;
    checks++;
    if (rd_b[63:0] !== 64'hB || rd_a[31:0] !== 32'hB) begin
      errors++; $display("FAIL bypass_post rd_b=%h rd_a=%h want b/b", rd_b[63:0], rd_a[31:0]);
    end
    $display("test_bypass done");
  endtask

  task automatic test_scoreboard();
    idle();
    rsv_en_a = 1'b1; rsv_addr_a = 5'd9;
    step(); idle(); ra_a = {5'd9, 5'd9}; #1;
    checks++;
    if (rd_busy_a !== 2'b11 || busy_vec_a[9] !== 1'b1) begin
      errors++; $display("FAIL sb_reserve rd_busy=%b busy9=%b want 11/1", rd_busy_a, busy_vec_a[9]);
    end
    we_a = 2'b10; wa_a = {5'd9, 5'd0}; wd_a = {32'h123, 32'h0}; #1;
    checks++;
    if (rd_busy_a !== 2'b00 || rd_a[31:0] !== 32'h123) begin
      errors++; $display("FAIL sb_write_mask rd_busy=%b rd=%h want 00/123", rd_busy_a, rd_a[31:0]);
    end
    step(); idle(); #1;
    checks++;
    if (busy_vec_a[9] !== 1'b0) begin
      errors++; $display("FAIL sb_write_clear busy9=%b want 0", busy_vec_a[9]);
    end
    we_a = 2'b01; wa_a = {5'd0, 5'd9}; rsv_en_a = 1'b1; rsv_addr_a = 5'd9;
    step(); idle(); #1;
    checks++;
    if (busy_vec_a[9] !== 1'b1) begin
      errors++; $display("FAIL sb_rsv_wins busy9=%b want 1", busy_vec_a[9]);
    end
    rsv_en_a = 1'b1; rsv_addr_a = 5'd9;
    step(); idle(); #1;
    checks++;
    if (busy_vec_a !== 32'h200) begin
      errors++; $display("FAIL sb_rsv_again busy=%h want 00000200", busy_vec_a);
    end
    rsv_en_b = 1'b1; rsv_addr_b = 4'd2;
    step(); idle();
    we_b = 1'b1; wa_b = 4'd2; wd_b = 64'h5; ra_b = {4'd0, 4'd0, 4'd2}; #1;
    checks++;
    if (rd_busy_b[0] !== 1'b1) begin
      errors++; $display("FAIL sb_no_bypass_busy rd_busy=%b want 1", rd_busy_b[0]);
    end
    step(); idle(); #1;
    checks++;
    if (busy_vec_b[2] !== 1'b0) begin
      errors++; $display("FAIL sb_no_bypass_clear busy2=%b want 0", busy_vec_b[2]);
    end
    $display("test_scoreboard done");
  endtask

  task automatic test_random_a(input int n);
    logic [31:0] m_reg [32];
    logic [31:0] m_busy;
    logic [4:0]  a;
    logic [31:0] exp_d;
    logic        exp_b;
    int          start_err;
    start_err = errors;
    rst = 1'b0; idle(); step(); rst = 1'b1;
    for (int k = 0; k < 32; k++) m_reg[k] = '0;
    m_busy = '0;
    for (int c = 0; c < n; c++) begin
      rst = ($urandom_range(0, 99) != 0);
      we_a = 2'($urandom); wa_a = 10'($urandom); wd_a = {$urandom, $urandom};
      rsv_en_a = 1'($urandom); rsv_addr_a = 5'($urandom); ra_a = 10'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        wa_a[9:5] = wa_a[4:0]; ra_a[4:0] = wa_a[4:0]; rsv_addr_a = wa_a[4:0];
      end
      #1;
      for (int j = 0; j < 2; j++) begin
        a = ra_a[j*5 +: 5];
        exp_d = m_reg[a]; exp_b = m_busy[a];
        for (int i = 0; i < 2; i++) begin
          if (we_a[i] && wa_a[i*5 +: 5] == a && a != 0) begin
            exp_d = wd_a[i*32 +: 32]; exp_b = 1'b0;
          end
        end
        if (a == 0 || !rst) begin exp_d = '0; exp_b = 1'b0; end
        checks++;
        if (rd_a[j*32 +: 32] !== exp_d || rd_busy_a[j] !== exp_b) begin
          errors++; $display("FAIL rand_a_read c=%0d port=%0d rd=%h busy=%b want %h/%b",
                             c, j, rd_a[j*32 +: 32], rd_busy_a[j], exp_d, exp_b);
        end
      end
      checks++;
      if (busy_vec_a !== (rst ? m_busy : 32'h0)) begin
        errors++; $display("FAIL rand_a_busyvec c=%0d got=%h want %h", c, busy_vec_a, rst ? m_busy : 32'h0);
      end
      if (!rst) begin
        for (int k = 0; k < 32; k++) m_reg[k] = '0;
        m_busy = '0;
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (we_a[i] && wa_a[i*5 +: 5] != 0) begin
            m_reg[wa_a[i*5 +: 5]] = wd_a[i*32 +: 32];
            m_busy[wa_a[i*5 +: 5]] = 1'b0;
          end
        end
        if (rsv_en_a && rsv_addr_a != 0) m_busy[rsv_addr_a] = 1'b1;
      end
      step();
    end
    rst = 1'b1; idle();
    $display("test_random_a cycles=%0d new_errors=%0d", n, errors - start_err);
  endtask

  task automatic test_random_b(input int n);
    logic [63:0] m_reg [16];
    logic [15:0] m_busy;
    logic [3:0]  a;
    logic [63:0] exp_d;
    logic        exp_b;
    int          start_err;
    start_err = errors;
    rst = 1'b0; idle(); step(); rst = 1'b1;
    for (int k = 0; k < 16; k++) m_reg[k] = '0;
    m_busy = '0;
    for (int c = 0; c < n; c++) begin
      rst = ($urandom_range(0, 199) != 0);
      we_b = 1'($urandom); wa_b = 4'($urandom); wd_b = {$urandom, $urandom};
      rsv_en_b = 1'($urandom); rsv_addr_b = 4'($urandom); ra_b = 12'($urandom);
      if ($urandom_range(0, 3) == 0) ra_b[3:0] = wa_b;
      #1;
      for (int j = 0; j < 3; j++) begin
        a = ra_b[j*4 +: 4];
        exp_d = m_reg[a]; exp_b = m_busy[a];
        if (a == 0 || !rst) begin exp_d = '0; exp_b = 1'b0; end
        checks++;
        if (rd_b[j*64 +: 64] !== exp_d || rd_busy_b[j] !== exp_b) begin
          errors++; $display("FAIL rand_b_read c=%0d port=%0d rd=%h busy=%b want %h/%b",
                             c, j, rd_b[j*64 +: 64], rd_busy_b[j], exp_d, exp_b);
        end
      end
      checks++;
      if (busy_vec_b !== (rst ? m_busy : 16'h0)) begin
        errors++; $display("FAIL rand_b_busyvec c=%0d got=%h want %h", c, busy_vec_b, rst ? m_busy : 16'h0);
      end
      if (!rst) begin
        for (int k = 0; k < 16; k++) m_reg[k] = '0;
        m_busy = '0;
      end else begin
        if (we_b[0] && wa_b != 0) begin
          m_reg[wa_b] = wd_b;
          m_busy[wa_b] = 1'b0;
        end
        if (rsv_en_b && rsv_addr_b != 0) m_busy[rsv_addr_b] = 1'b1;
      end
      step();
    end
    rst = 1'b1; idle();
    $display("test_random_b cycles=%0d new_errors=%0d", n, errors - start_err);
  endtask

  initial begin
    rst = 1'b0;
    idle();
    test_reset();
    test_zero_reg();
    test_collision();
    test_bypass();
    test_scoreboard();
    test_random_a(3000);
    test_random_b(10000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
